// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator with a one-clock output stage.
//
// Stage 0 holds the pixel position and its syncs, active flag and frame
// start pulse. All of them are registered from one next-count calculation,
// so they always describe the same pixel.
// Stage 1 delays the syncs by one clock. It also samples the colour inputs
// while stage 0 is active and drives 0 otherwise, so the colour lines up
// with the syncs at the connector.
//
// Ports
//   i_Clk, i_Rst_L            pixel clock, async active-low reset
//   i_Enable                  high runs the timing; low returns to IDLE
//   i_Red/Grn/Blu_Video[3:0]  colour for the current stage-0 position
//   o_Col_Count/o_Row_Count   stage-0 position (10 bit)
//   o_HSync/o_VSync           stage-0 syncs, active low
//   o_Active                  stage-0 visible-area flag
//   o_Frame_Start             one-clock pulse at position (0,0)
//   o_VGA_HSync/o_VGA_VSync   stage-1 syncs
//   o_VGA_Red/Grn/Blu[3:0]    stage-1 blanked colour
module vga_sync_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 18,
  parameter int H_SYNC_WIDTH  = 92,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Enable,
  input  logic [3:0] i_Red_Video,
  input  logic [3:0] i_Grn_Video,
  input  logic [3:0] i_Blu_Video,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Active,
  output logic       o_Frame_Start,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic [3:0] o_VGA_Red,
  output logic [3:0] o_VGA_Grn,
  output logic [3:0] o_VGA_Blu
);

  localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HS_FIRST = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] HS_LAST  = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [9:0] VS_FIRST = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] VS_LAST  = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [9:0] col_q, col_d, row_q, row_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       active_q, active_d, fs_q, fs_d;
  logic       vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
  logic [3:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;

  // Stage 0. Every output comes from the next count (col_d,row_d). The
  // first RUN cycle and a frame wrap both land on (0,0), so one compare
  // produces the frame-start pulse for both cases.
  always_comb begin
    state_d = i_Enable ? RUN : IDLE;
    col_d   = '0;
    row_d   = '0;
    if (i_Enable && state_q == RUN) begin
      if (col_q >= COL_LAST) begin
        col_d = '0;
        row_d = (row_q >= ROW_LAST) ? 10'd0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
        row_d = row_q;
      end
    end
    fs_d     = i_Enable && (col_d == 10'd0) && (row_d == 10'd0);
    active_d = i_Enable && (col_d < ACT_COLS) && (row_d < ACT_ROWS);
    hsync_d  = !(i_Enable && (col_d >= HS_FIRST) && (col_d <= HS_LAST));
    vsync_d  = !(i_Enable && (row_d >= VS_FIRST) && (row_d <= VS_LAST));
  end

  // Stage 1. active_q is 0 in IDLE, so it alone gates the colour.
  always_comb begin
    vga_hs_d = hsync_q;
    vga_vs_d = vsync_q;
    red_d    = active_q ? i_Red_Video : 4'd0;
    grn_d    = active_q ? i_Grn_Video : 4'd0;
    blu_d    = active_q ? i_Blu_Video : 4'd0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
      vga_hs_q <= 1'b1;
      vga_vs_q <= 1'b1;
      red_q    <= '0;
      grn_q    <= '0;
      blu_q    <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      fs_q     <= fs_d;
      vga_hs_q <= vga_hs_d;
      vga_vs_q <= vga_vs_d;
      red_q    <= red_d;
      grn_q    <= grn_d;
      blu_q    <= blu_d;
    end
  end

  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Active      = active_q;
  assign o_Frame_Start = fs_q;
  assign o_VGA_HSync   = vga_hs_q;
  assign o_VGA_VSync   = vga_vs_q;
  assign o_VGA_Red     = red_q;
  assign o_VGA_Grn     = grn_q;
  assign o_VGA_Blu     = blu_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. One instance uses the default 640x480 timing.
// A second, scaled instance makes whole frames short enough to cover the
// frame-wrap, frame-period and pixel-count corners. Both instances share
// the same stimulus.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] col, row;
    logic       hs, vs, act, fs, vhs, vvs;
    logic [3:0] vr, vg, vb;
  } obs_t;

  typedef struct {
    int tc, tr, ac, ar, hfp, hsw, vfp, vsw;
  } tim_t;

  typedef struct packed {
    obs_t b;
    obs_t s;
  } exp_t;

  typedef struct {
    logic       en;
    logic [3:0] r, g, b;
    logic [9:0] col, row;
    logic       fs, act, hs;
    logic [3:0] vr;
  } vec_t;

  localparam obs_t IDLE_OBS = '{col: 10'd0, row: 10'd0, hs: 1'b1, vs: 1'b1, act: 1'b0,
                                fs: 1'b0, vhs: 1'b1, vvs: 1'b1, vr: 4'd0, vg: 4'd0, vb: 4'd0};

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [3:0] r, g, b;
  always #5 clk = ~clk;

  logic [9:0] b_col, b_row, s_col, s_row;
  logic       b_hs, b_vs, b_act, b_fs, b_vhs, b_vvs;
  logic       s_hs, s_vs, s_act, s_fs, s_vhs, s_vvs;
  logic [3:0] b_vr, b_vg, b_vb, s_vr, s_vg, s_vb;
  obs_t       b_o, s_o;
  assign b_o = {b_col, b_row, b_hs, b_vs, b_act, b_fs, b_vhs, b_vvs, b_vr, b_vg, b_vb};
  assign s_o = {s_col, s_row, s_hs, s_vs, s_act, s_fs, s_vhs, s_vvs, s_vr, s_vg, s_vb};

  vga_sync_gen u_big (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
    .i_Red_Video(r), .i_Grn_Video(g), .i_Blu_Video(b),
    .o_Col_Count(b_col), .o_Row_Count(b_row), .o_HSync(b_hs), .o_VSync(b_vs),
    .o_Active(b_act), .o_Frame_Start(b_fs), .o_VGA_HSync(b_vhs), .o_VGA_VSync(b_vvs),
    .o_VGA_Red(b_vr), .o_VGA_Grn(b_vg), .o_VGA_Blu(b_vb));

  vga_sync_gen #(
    .TOTAL_COLS(20), .TOTAL_ROWS(12), .ACTIVE_COLS(12), .ACTIVE_ROWS(8),
    .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2)
  ) u_small (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en),
    .i_Red_Video(r), .i_Grn_Video(g), .i_Blu_Video(b),
    .o_Col_Count(s_col), .o_Row_Count(s_row), .o_HSync(s_hs), .o_VSync(s_vs),
    .o_Active(s_act), .o_Frame_Start(s_fs), .o_VGA_HSync(s_vhs), .o_VGA_VSync(s_vvs),
    .o_VGA_Red(s_vr), .o_VGA_Grn(s_vg), .o_VGA_Blu(s_vb));

  tim_t tb_t = '{tc: 800, tr: 525, ac: 640, ar: 480, hfp: 18, hsw: 92, vfp: 10, vsw: 2};
  tim_t ts_t = '{tc: 20,  tr: 12,  ac: 12,  ar: 8,   hfp: 2,  hsw: 3,  vfp: 1,  vsw: 2};

  int   n_cmp = 0, n_bad = 0;
  int   t = 0;
  logic running = 1'b0;
  obs_t eb = IDLE_OBS, es = IDLE_OBS;
  exp_t sb[$];

  // Reference: the position is derived from the number of clocks since
  // enable, not from a running counter.
  function automatic obs_t model(input tim_t p, input logic run, input int tt,
                                 input obs_t prev, input logic [3:0] rr, gg, bb);
    obs_t o;
    int c, rw;
    o = IDLE_OBS;
    if (run) begin
      c     = tt % p.tc;
      rw    = (tt / p.tc) % p.tr;
      o.col = 10'(c);
      o.row = 10'(rw);
      o.act = (c < p.ac) && (rw < p.ar);
      o.hs  = !((c >= p.ac + p.hfp) && (c < p.ac + p.hfp + p.hsw));
      o.vs  = !((rw >= p.ar + p.vfp) && (rw < p.ar + p.vfp + p.vsw));
      o.fs  = (tt % (p.tc * p.tr)) == 0;
    end
    o.vhs = prev.hs;
    o.vvs = prev.vs;
    o.vr  = prev.act ? rr : 4'd0;
    o.vg  = prev.act ? gg : 4'd0;
    o.vb  = prev.act ? bb : 4'd0;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Entered just after a falling edge: drive, predict, push, clock, pop, compare.
  task automatic step(input logic e, input logic [3:0] rr, gg, bb);
    exp_t x;
    en = e; r = rr; g = gg; b = bb;
    if (e) t = running ? t + 1 : 0;
    running = e;
    eb = model(tb_t, e, t, eb, rr, gg, bb);
    es = model(ts_t, e, t, es, rr, gg, bb);
    sb.push_back('{b: eb, s: es});
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    chk("big_obs", 64'(b_o), 64'(x.b));
    chk("small_obs", 64'(s_o), 64'(x.s));
  endtask

  initial begin
    vec_t vecs[7];
    int cyc, fs_last, win, pix, vs_low, hs_first, hs_len;
    logic [9:0] pbc, pbr, psc, psr;
    logic found;

    vecs[0] = '{1'b1, 4'hF, 4'h0, 4'h0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 4'h0};
    vecs[1] = '{1'b1, 4'hF, 4'h0, 4'h0, 10'd1, 10'd0, 1'b0, 1'b1, 1'b1, 4'hF};
    vecs[2] = '{1'b1, 4'hF, 4'h0, 4'h0, 10'd2, 10'd0, 1'b0, 1'b1, 1'b1, 4'hF};
    vecs[3] = '{1'b0, 4'hF, 4'h0, 4'h0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 4'hF};
    vecs[4] = '{1'b0, 4'hF, 4'h0, 4'h0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 4'h0};
    vecs[5] = '{1'b1, 4'h7, 4'h0, 4'h0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 4'h0};
    vecs[6] = '{1'b1, 4'hA, 4'h0, 4'h0, 10'd1, 10'd0, 1'b0, 1'b1, 1'b1, 4'hA};

    rst_n = 1'b0; en = 1'b0; r = '0; g = '0; b = '0;
    @(negedge clk);
    chk("reset_big", 64'(b_o), 64'(IDLE_OBS));
    chk("reset_small", 64'(s_o), 64'(IDLE_OBS));
    rst_n = 1'b1;

    // Start-up and enable toggling.
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].r, vecs[i].g, vecs[i].b);
      chk($sformatf("vec%0d", i), {b_col, b_row, b_fs, b_act, b_hs, b_vr},
          {vecs[i].col, vecs[i].row, vecs[i].fs, vecs[i].act, vecs[i].hs, vecs[i].vr});
    end

    // Free run with constant colour.
    cyc = 0; fs_last = -1; win = -1; pix = 0; vs_low = 0; hs_first = -1; hs_len = 0;
    for (int k = 0; k < 1700; k++) begin
      pbc = b_col; pbr = b_row; psc = s_col; psr = s_row;
      step(1'b1, 4'h5, 4'hA, 4'hC);
      cyc++;
      if (pbc == 10'd799 && pbr == 10'd0)
        chk("big_wrap_line", {b_col, b_row}, {10'd0, 10'd1});
      if (psc == 10'd19 && psr == 10'd11)
        chk("small_wrap_frame", {s_col, s_row, s_fs}, {10'd0, 10'd0, 1'b1});
      if (b_row == 10'd0 && !b_hs) begin
        if (hs_first < 0) hs_first = int'(b_col);
        hs_len++;
      end
      if (win >= 0 && cyc > win && cyc <= win + 240 && s_vr == 4'h5 && s_vg == 4'hA && s_vb == 4'hC)
        pix++;
      if (win >= 0 && cyc >= win && cyc < win + 240 && !s_vs)
        vs_low++;
      if (s_fs) begin
        if (fs_last >= 0) chk("small_fs_period", 64'(cyc - fs_last), 64'd240);
        fs_last = cyc;
        if (win < 0) win = cyc;
      end
    end
    chk("big_hs_first_col", 64'(hs_first), 64'd658);
    chk("big_hs_len", 64'(hs_len), 64'd92);
    chk("small_pixels", 64'(pix), 64'd96);
    chk("small_vs_low_clks", 64'(vs_low), 64'd40);

    // Drop enable mid-line for 10 clocks, then restart.
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (b_col == 10'd300) found = 1'b1;
      else step(1'b1, 4'h5, 4'hA, 4'hC);
    end
    chk("reach_col300", 64'(found), 64'd1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'h5, 4'hA, 4'hC);
      chk("disabled_idle", {b_col, b_row, b_hs, b_vs, b_act}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b0});
    end
    step(1'b1, 4'h5, 4'hA, 4'hC);
    chk("restart", {b_col, b_row, b_fs, s_col, s_row, s_fs}, {10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b1});

    // Async reset between edges while the big instance is in hsync.
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (b_col == 10'd660 && !b_hs && !b_vhs) found = 1'b1;
      else step(1'b1, 4'h5, 4'hA, 4'hC);
    end
    chk("reach_hsync", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_big", 64'(b_o), 64'(IDLE_OBS));
    chk("async_rst_small", 64'(s_o), 64'(IDLE_OBS));
    @(negedge clk);
    chk("rst_held", 64'(b_o), 64'(IDLE_OBS));
    running = 1'b0; eb = IDLE_OBS; es = IDLE_OBS;
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) step(1'b1, 4'h3, 4'h6, 4'h9);
    chk("queue_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800, meaning pixel clocks per line.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525, meaning lines per frame.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640, meaning visible pixels per line.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480, meaning visible lines per frame.
REQ-005 SHALL have parameters H_FRONT_PORCH 18, H_SYNC_WIDTH 92, V_FRONT_PORCH 10, V_SYNC_WIDTH 2, meaning porch and sync lengths in clocks or lines.
REQ-006 SHALL have port i_Clk, input, 1 bit, the single pixel clock; all logic is on its rising edge.
REQ-007 SHALL have port i_Rst_L, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port i_Enable, input, 1 bit, which runs the timing when high.
REQ-009 SHALL have ports i_Red_Video, i_Grn_Video and i_Blu_Video, input, 4 bits each, pixel colour for the current stage-0 count.
REQ-010 SHALL have ports o_Col_Count and o_Row_Count, output, 10 bits each, the stage-0 pixel position.
REQ-011 SHALL have ports o_HSync and o_VSync, output, 1 bit each, stage-0 syncs, active low.
REQ-012 SHALL have port o_Active, output, 1 bit, high at stage 0 when the count is inside the visible area.
REQ-013 SHALL have port o_Frame_Start, output, 1 bit, a one-clock pulse at count (0,0).
REQ-014 SHALL have ports o_VGA_HSync and o_VGA_VSync, output, 1 bit each, stage-1 syncs to the connector.
REQ-015 SHALL have ports o_VGA_Red, o_VGA_Grn and o_VGA_Blu, output, 4 bits each, stage-1 blanked colour.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and RUN.
- IDLE -> RUN on the first edge with i_Enable=1.
- RUN -> IDLE on any edge with i_Enable=0.
REQ-017 On entering RUN, SHALL load col=0 and row=0, and raise o_Frame_Start for that one cycle.
REQ-018 In RUN, SHALL increment col each clock; at col=TOTAL_COLS-1, col wraps to 0 and row increments.
REQ-019 At col=TOTAL_COLS-1 with row=TOTAL_ROWS-1, both SHALL wrap to 0 and o_Frame_Start SHALL pulse.
REQ-020 In IDLE, SHALL hold the counts at 0, o_HSync/o_VSync at 1, and o_Active and o_Frame_Start at 0.
REQ-021 Stage-0 outputs (counts, o_HSync, o_VSync, o_Active, o_Frame_Start) SHALL be registered and mutually consistent on every cycle.
REQ-022 o_Active SHALL be 1 in RUN iff col<ACTIVE_COLS and row<ACTIVE_ROWS.
REQ-023 o_HSync SHALL be 0 in RUN iff col is within [ACTIVE_COLS+H_FRONT_PORCH, ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH-1], which is [658,749] at the defaults.
REQ-024 o_VSync SHALL be 0 in RUN iff row is within [ACTIVE_ROWS+V_FRONT_PORCH, ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH-1], which is [490,491] at the defaults; it changes on the same edge as row.
REQ-025 Stage 1 SHALL register the stage-0 values once, giving exactly one clock of latency.
- o_VGA_HSync = o_HSync delayed one clock.
- o_VGA_VSync = o_VSync delayed one clock.
- o_VGA_Red/Grn/Blu = i_Red/Grn/Blu_Video sampled while o_Active=1, otherwise 0.
REQ-026 Colour inputs SHALL be ignored (output 0) whenever o_Active=0 or the FSM is IDLE.
REQ-027 Counter arithmetic SHALL be 10-bit unsigned, and counts SHALL never exceed TOTAL_COLS-1 or TOTAL_ROWS-1.
REQ-028 Toggling i_Enable mid-frame SHALL abandon the frame; re-enabling always restarts at (0,0) with a frame-start pulse.

Reset
REQ-029 While i_Rst_L=0, asynchronously and independent of i_Clk, SHALL force:
- FSM to IDLE;
- counts to 0;
- o_HSync, o_VSync, o_VGA_HSync and o_VGA_VSync to 1;
- o_Active, o_Frame_Start and all o_VGA colour outputs to 0.
REQ-030 After i_Rst_L rises, behaviour SHALL follow REQ-016/017; reset asserted mid-frame aborts immediately with no partial pulse.

Verification
REQ-031 Reset release with i_Enable=1 and colour F/0/0 -> the first edge gives count (0,0), o_Frame_Start=1 and o_Active=1; the next edge gives o_VGA_Red=F and o_Frame_Start=0.
REQ-032 Free-run two frames -> o_Frame_Start period is exactly 420000 clocks; o_HSync is low for 92 clocks per line, starting at col 658; o_VSync is low for 2 lines (rows 490-491) per frame.
REQ-033 Drive colour 5/A/C constantly -> o_VGA outputs are 5/A/C only in the clock after o_Active=1, giving 640x480 = 307200 nonzero pixels per frame and 0 elsewhere.
REQ-034 Check wrap points -> count (799,0) is followed by (0,1), and (799,524) is followed by (0,0) with an o_Frame_Start pulse.
REQ-035 Drop i_Enable at count (300,200) for 10 clocks, then raise it -> counts 0 and syncs 1 while low; the first edge high gives (0,0) with o_Frame_Start=1.
REQ-036 Assert i_Rst_L=0 between clock edges mid-sync -> o_HSync and o_VGA_HSync go to 1 and the counts go to 0 before the next i_Clk edge.
